lighting_mode_ctrl: RTL and testbench

//  Lamp sequencing controller. Consumes the one-cycle short/long press events from the push-button

---
 rtl/lighting_pkg.sv | 26 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/lighting_mode_ctrl.sv | 137 +++++++++++++
 tb/tb_lighting_mode_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/lighting_pkg.sv
// Shared state encoding and decode helpers for the lamp sequencing controller.
package lighting_pkg;

  typedef enum logic [2:0] {
    AUTO_IDLE    = 3'd0,
    AUTO_ON      = 3'd1,
    AUTO_HOLD    = 3'd2,
    AUTO_INHIBIT = 3'd3,
    MAN_OFF      = 3'd4,
    MAN_ON       = 3'd5
  } ctrl_state_t;

  function automatic logic lamp_on_f(ctrl_state_t s);
    return (s == AUTO_ON) || (s == AUTO_HOLD) || (s == MAN_ON);
  endfunction

  function automatic logic auto_mode_f(ctrl_state_t s);
    return (s == AUTO_IDLE) || (s == AUTO_ON) ||
           (s == AUTO_HOLD) || (s == AUTO_INHIBIT);
  endfunction

  function automatic int max_f(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous sensor levels.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/lighting_mode_ctrl.sv
// Lamp sequencing controller: AUTO (presence + off-delay) and MANUAL
// (toggle) modes, switched by long press.
module lighting_mode_ctrl
  import lighting_pkg::*;
#(
  parameter int OFF_DELAY_T = 10000,
  parameter int INHIBIT_T   = 3000
) (
  input  logic clk,
  input  logic rst,
  input  logic short_press,
  input  logic long_press,
  input  logic presence,
  output logic lamp_on,
  output logic auto_mode,
  output logic inhibit
);

  localparam int CW =
    $clog2(max_f(OFF_DELAY_T, INHIBIT_T) + 1);
  localparam logic [CW-1:0] OFF_LD = CW'(OFF_DELAY_T - 1);
  localparam logic [CW-1:0] INH_LD = CW'(INHIBIT_T - 1);

  if (OFF_DELAY_T < 1 || INHIBIT_T < 1) begin : g_bad_param
    $error("OFF_DELAY_T and INHIBIT_T must be >= 1");
  end

  logic pres_s;

  sync_2ff u_pres_sync (
    .clk (clk),
    .rst (rst),
    .d_i (presence),
    .q_o (pres_s)
  );

  ctrl_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lamp_q, auto_q, inh_q;
  logic          cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      AUTO_IDLE: begin
        if (long_press) begin
          state_d = MAN_OFF;
        end else if (short_press) begin
          state_d = AUTO_HOLD;
          cnt_d   = OFF_LD;
        end else if (pres_s) begin
          state_d = AUTO_ON;
        end
      end
      AUTO_ON: begin
        if (long_press) begin
          state_d = MAN_ON;
        end else if (short_press) begin
          state_d = AUTO_INHIBIT;
          cnt_d   = INH_LD;
        end else if (!pres_s) begin
          state_d = AUTO_HOLD;
          cnt_d   = OFF_LD;
        end
      end
      AUTO_HOLD: begin
        if (long_press) begin
          state_d = MAN_ON;
        end else if (short_press) begin
          state_d = AUTO_INHIBIT;
          cnt_d   = INH_LD;
        end else if (pres_s) begin
          state_d = AUTO_ON;
        end else if (cnt_zero) begin
          state_d = AUTO_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      AUTO_INHIBIT: begin
        if (long_press) begin
          state_d = MAN_OFF;
        end else if (short_press) begin
          state_d = AUTO_HOLD;
          cnt_d   = OFF_LD;
        end else if (cnt_zero) begin
          state_d = AUTO_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      MAN_OFF: begin
        if (long_press) begin
          state_d = AUTO_IDLE;
        end else if (short_press) begin
          state_d = MAN_ON;
        end
      end
      MAN_ON: begin
        // lamp stays lit across the mode change
        if (long_press) begin
          state_d = AUTO_HOLD;
          cnt_d   = OFF_LD;
        end else if (short_press) begin
          state_d = MAN_OFF;
        end
      end
      default: begin
        state_d = AUTO_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= AUTO_IDLE;
      cnt_q   <= '0;
      lamp_q  <= 1'b0;
      auto_q  <= 1'b1;
      inh_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lamp_q  <= lamp_on_f(state_d);
      auto_q  <= auto_mode_f(state_d);
      inh_q   <= (state_d == AUTO_INHIBIT);
    end
  end

  assign lamp_on   = lamp_q;
  assign auto_mode = auto_q;
  assign inhibit   = inh_q;

endmodule

// File: tb/tb_lighting_mode_ctrl.sv
// Bench for lighting_mode_ctrl: vector table, corner sequences, random run.
module tb_lighting_mode_ctrl;

  localparam int OFF = 8;
  localparam int INH = 4;

  logic clk = 1'b0;
  logic rst, sp, lp, pres;
  logic lamp_on, auto_mode, inhibit;

  int checks = 0;
  int errors = 0;

  lighting_mode_ctrl #(
    .OFF_DELAY_T (OFF),
    .INHIBIT_T   (INH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .short_press (sp),
    .long_press  (lp),
    .presence    (pres),
    .lamp_on     (lamp_on),
    .auto_mode   (auto_mode),
    .inhibit     (inhibit)
  );

  always #5 clk = ~clk;

  // behavioural model: mode flag, lamp flag, remaining hold/inhibit time
  bit m_auto, m_on, m_ps0, m_ps1;
  int m_hold, m_inh;

  task automatic model_edge(bit r, bit s, bit l, bit p);
    bit ps, lit;
    if (r) begin
      m_auto = 1; m_on = 0; m_hold = 0; m_inh = 0;
      m_ps0 = 0; m_ps1 = 0;
      return;
    end
    ps = m_ps1;
    m_ps1 = m_ps0;
    m_ps0 = p;
    lit = m_on || (m_hold > 0);
    if (!m_auto) begin
      if (l) begin
        m_auto = 1;
        if (m_on) begin m_on = 0; m_hold = OFF; end
      end else if (s) m_on = !m_on;
    end else if (l) begin
      m_auto = 0; m_on = lit; m_hold = 0; m_inh = 0;
    end else if (s) begin
      if (lit) begin m_inh = INH; m_hold = 0; m_on = 0; end
      else begin m_hold = OFF; m_inh = 0; m_on = 0; end
    end else if (m_inh > 0) begin
      m_inh--;
    end else if (m_hold > 0) begin
      if (ps) begin m_on = 1; m_hold = 0; end
      else m_hold--;
    end else if (m_on) begin
      if (!ps) begin m_on = 0; m_hold = OFF; end
    end else if (ps) begin
      m_on = 1;
    end
  endtask

  task automatic chk(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(bit r, bit s, bit l, bit p);
    @(negedge clk);
    rst = r; sp = s; lp = l; pres = p;
    @(posedge clk);
    #1;
    model_edge(r, s, l, p);
    chk("model_lamp", lamp_on, m_on || (m_hold > 0));
    chk("model_auto", auto_mode, m_auto);
    chk("model_inh", inhibit, m_auto && (m_inh > 0));
  endtask

  typedef struct {
    bit r, s, l, p;
    bit e_lamp, e_auto, e_inh;
  } vec_t;

  vec_t tbl[$];

  task automatic add(bit r, bit s, bit l, bit p,
                     bit el, bit ea, bit ei);
    vec_t v;
    v.r = r; v.s = s; v.l = l; v.p = p;
    v.e_lamp = el; v.e_auto = ea; v.e_inh = ei;
    tbl.push_back(v);
  endtask

  initial begin
    rst = 1; sp = 0; lp = 0; pres = 0;

    add(1,0,0,0, 0,1,0);
    add(1,0,0,0, 0,1,0);
    add(0,0,1,0, 0,0,0);
    add(0,1,0,0, 1,0,0);
    add(0,1,0,0, 0,0,0);
    add(0,1,0,0, 1,0,0);
    add(0,0,1,0, 1,1,0);
    for (int i = 0; i < OFF - 1; i++) add(0,0,0,0, 1,1,0);
    add(0,0,0,0, 0,1,0);
    add(0,0,1,0, 0,0,0);
    add(0,1,1,0, 0,1,0);
    add(0,1,0,0, 1,1,0);
    add(0,1,0,0, 0,1,1);
    for (int i = 0; i < INH - 1; i++) add(0,0,0,0, 0,1,1);
    add(0,0,0,0, 0,1,0);
    add(0,1,0,0, 1,1,0);
    add(0,0,0,0, 1,1,0);
    add(1,0,0,0, 0,1,0);
    add(0,0,0,0, 0,1,0);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].s, tbl[i].l, tbl[i].p);
      chk("tbl_lamp", lamp_on, tbl[i].e_lamp);
      chk("tbl_auto", auto_mode, tbl[i].e_auto);
      chk("tbl_inh", inhibit, tbl[i].e_inh);
    end

    // presence rise: lamp after 3rd edge; fall: on for sync + OFF cycles
    step(1,0,0,0);
    step(0,0,0,1); chk("pres_e0", lamp_on, 1'b0);
    step(0,0,0,1); chk("pres_e1", lamp_on, 1'b0);
    step(0,0,0,1); chk("pres_e2", lamp_on, 1'b1);
    for (int i = 0; i < 2 + OFF; i++) begin
      step(0,0,0,0); chk("hold_on", lamp_on, 1'b1);
    end
    step(0,0,0,0); chk("hold_off", lamp_on, 1'b0);

    // short press in AUTO_ON inhibits despite presence
    for (int i = 0; i < 3; i++) step(0,0,0,1);
    chk("inh_pre_on", lamp_on, 1'b1);
    step(0,1,0,1);
    chk("inh_lamp", lamp_on, 1'b0);
    chk("inh_flag", inhibit, 1'b1);
    for (int i = 0; i < INH - 1; i++) begin
      step(0,0,0,1); chk("inh_hold", inhibit, 1'b1);
      chk("inh_dark", lamp_on, 1'b0);
    end
    step(0,0,0,1);
    chk("inh_end", inhibit, 1'b0);
    chk("inh_idle", lamp_on, 1'b0);
    step(0,0,0,1); chk("inh_reon", lamp_on, 1'b1);

    // presence returns on the cnt==1 HOLD cycle: lamp must never drop
    for (int i = 0; i < 7; i++) begin
      step(0,0,0,0); chk("rerise_a", lamp_on, 1'b1);
    end
    for (int i = 0; i < 12; i++) begin
      step(0,0,0,1); chk("rerise_b", lamp_on, 1'b1);
    end
    chk("rerise_auto", auto_mode, 1'b1);

    // random run against the model
    for (int i = 0; i < 3000; i++) begin
      bit r, s, l;
      r = ($urandom_range(0, 99) == 0);
      s = ($urandom_range(0, 7) == 0);
      l = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 9) == 0) pres = ~pres;
      step(r, s, l, pres);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
